// File: rtl/axi_reg_pkg.sv
// Shared definitions for the AXI3 register bank.
//   - Register slot indices and byte offsets of the register map
//   - Write / read FSM state encodings
//   - AXI response codes
package axi_reg_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register slot indices (addr[2+:IDX_W])
    localparam int unsigned IDX_CTRL     = 0;
    localparam int unsigned IDX_IRQ_EN   = 1;
    localparam int unsigned IDX_IRQ_PEND = 2;
    localparam int unsigned IDX_COUNT    = 3;
    localparam int unsigned IDX_SCRATCH0 = 4;

    // Byte offsets of the same registers
    localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] OFF_IRQ_EN   = 32'h0000_0004;
    localparam logic [31:0] OFF_IRQ_PEND = 32'h0000_0008;
    localparam logic [31:0] OFF_COUNT    = 32'h0000_000C;
    localparam logic [31:0] OFF_SCRATCH0 = 32'h0000_0010;

    // Write channel FSM
    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    // Read channel FSM
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_strb_merge.sv
// Byte-strobed merge of two words.
//   old_data : current register contents
//   new_data : candidate contents (write data, or W1C result)
//   strb     : one bit per byte; 1 takes the byte from new_data
//   merged   : result, bytes with strb=0 come from old_data
module axi_strb_merge #(
    parameter int BYTES = 4
) (
    input  logic [8*BYTES-1:0] old_data,
    input  logic [8*BYTES-1:0] new_data,
    input  logic [BYTES-1:0]   strb,
    output logic [8*BYTES-1:0] merged
);

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte
        assign merged[8*gi +: 8] = strb[gi] ? new_data[8*gi +: 8] : old_data[8*gi +: 8];
    end

endmodule

// File: rtl/axi_reg_bank.sv
// AXI3 slave register bank with LED control, interrupt controller and
// free-running cycle counter.
//   clock, resetn           : single clock, asynchronous active-low reset
//   s_aw* / s_w* / s_b*     : AXI3 write address, data (single beat), response
//   s_ar* / s_r*            : AXI3 read address and data
//   irq_src                 : hardware event lines, rising edge sets IRQ_PEND
//   leds                    : CTRL[LED_W-1:0]
//   irq                     : registered |(IRQ_PEND & IRQ_EN)
// Map: 0x00 CTRL, 0x04 IRQ_EN, 0x08 IRQ_PEND (W1C), 0x0C COUNT (RO),
//      0x10.. SCRATCH; offsets at or beyond 4*NUM_REGS answer SLVERR.
module axi_reg_bank
    import axi_reg_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ID_W     = 12,
    parameter int LED_W    = 4,
    parameter int N_IRQ    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [31:0]      s_awaddr,
    input  logic [ID_W-1:0]  s_awid,
    input  logic [2:0]       s_awprot,
    input  logic             s_awvalid,
    output logic             s_awready,
    input  logic [31:0]      s_wdata,
    input  logic [3:0]       s_wstrb,
    input  logic [ID_W-1:0]  s_wid,
    input  logic             s_wvalid,
    output logic             s_wready,
    output logic [1:0]       s_bresp,
    output logic [ID_W-1:0]  s_bid,
    output logic             s_bvalid,
    input  logic             s_bready,
    input  logic [31:0]      s_araddr,
    input  logic [ID_W-1:0]  s_arid,
    input  logic [2:0]       s_arprot,
    input  logic             s_arvalid,
    output logic             s_arready,
    output logic [31:0]      s_rdata,
    output logic [1:0]       s_rresp,
    output logic [ID_W-1:0]  s_rid,
    output logic             s_rlast,
    output logic             s_rvalid,
    input  logic             s_rready,
    input  logic [N_IRQ-1:0] irq_src,
    output logic [LED_W-1:0] leds,
    output logic             irq
);

    localparam int          IDX_W    = $clog2(NUM_REGS);
    localparam logic [31:0] LIMIT    = 32'(4 * NUM_REGS);
    localparam logic [31:0] IRQ_MASK = 32'((64'd1 << N_IRQ) - 64'd1);

    // Write channel state
    w_state_e          w_state_q, w_state_d;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [31:0]       awaddr_q,  awaddr_d;
    logic [ID_W-1:0]   awid_q,    awid_d;
    logic [31:0]       wdata_q,   wdata_d;
    logic [3:0]        wstrb_q,   wstrb_d;
    logic [ID_W-1:0]   bid_q,     bid_d;
    logic [1:0]        bresp_q,   bresp_d;

    // Read channel state
    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   rid_q,     rid_d;
    logic [31:0]       rdata_q,   rdata_d;
    logic [1:0]        rresp_q,   rresp_d;

    // Register storage; slots IDX_IRQ_PEND and IDX_COUNT are never written
    // here because those registers live in pend_q and count_q.
    logic [31:0]       regs_q [NUM_REGS];
    logic [31:0]       regs_d [NUM_REGS];
    logic [N_IRQ-1:0]  pend_q,  pend_d;
    logic [N_IRQ-1:0]  src_prev_q;
    logic [31:0]       count_q, count_d;
    logic              irq_q,   irq_d;

    logic              aw_fire, w_fire, ar_fire, commit, w_err, rd_err;
    logic [IDX_W-1:0]  w_idx, rd_idx;
    logic [31:0]       pend32, rw_merged, w1c_merged, rd_val;

    // Protection bits and WID carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{s_awprot, s_arprot, s_wid};

    // Handshake readies are gated by resetn so they read 0 while reset is
    // asserted and 1 immediately after release.
    assign s_awready = resetn && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_wready  = resetn && (w_state_q == W_IDLE) && !w_held_q;
    assign s_arready = resetn && (r_state_q == R_IDLE);

    assign aw_fire = s_awvalid && s_awready;
    assign w_fire  = s_wvalid  && s_wready;
    assign ar_fire = s_arvalid && s_arready;

    // Register update happens the cycle after both halves are held.
    assign commit = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    assign w_err  = (awaddr_q >= LIMIT);
    assign w_idx  = awaddr_q[2 +: IDX_W];
    assign rd_err = (s_araddr >= LIMIT);
    assign rd_idx = s_araddr[2 +: IDX_W];

    always_comb begin
        pend32 = '0;
        pend32[N_IRQ-1:0] = pend_q;
    end

    // Ordinary read-write merge for the addressed register.
    axi_strb_merge #(.BYTES(4)) u_rw_merge (
        .old_data (regs_q[w_idx]),
        .new_data (wdata_q),
        .strb     (wstrb_q),
        .merged   (rw_merged)
    );

    // W1C: strobed bytes take pend & ~wdata, unstrobed bytes keep pend.
    axi_strb_merge #(.BYTES(4)) u_w1c_merge (
        .old_data (pend32),
        .new_data (pend32 & ~wdata_q),
        .strb     (wstrb_q),
        .merged   (w1c_merged)
    );

    // Write channel
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        awid_d    = awid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        if (w_state_q == W_IDLE) begin
            if (aw_fire) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_awaddr;
                awid_d    = s_awid;
            end
            if (w_fire) begin
                w_held_d = 1'b1;
                wdata_d  = s_wdata;
                wstrb_d  = s_wstrb;
            end
            if (commit) begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bid_d     = awid_q;
                bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
                w_state_d = W_RESP;
            end
        end else if (s_bready) begin
            w_state_d = W_IDLE;
        end
    end

    // Register file, interrupt pending, counter
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        pend_d = pend_q;
        if (commit && !w_err) begin
            if (w_idx == IDX_W'(IDX_IRQ_EN)) begin
                regs_d[IDX_IRQ_EN] = rw_merged & IRQ_MASK;
            end else if (w_idx == IDX_W'(IDX_IRQ_PEND)) begin
                pend_d = w1c_merged[N_IRQ-1:0];
            end else if (w_idx != IDX_W'(IDX_COUNT)) begin
                regs_d[w_idx] = rw_merged;
            end
        end
        // Edge set is applied after W1C so a coincident event is not lost.
        pend_d  = pend_d | (irq_src & ~src_prev_q);
        count_d = count_q + 32'd1;
        irq_d   = |(pend_q & regs_q[IDX_IRQ_EN][N_IRQ-1:0]);
    end

    // Read channel; values are sampled before any same-cycle write lands.
    always_comb begin
        rd_val = '0;
        if (!rd_err) begin
            if (rd_idx == IDX_W'(IDX_IRQ_PEND)) begin
                rd_val = pend32;
            end else if (rd_idx == IDX_W'(IDX_COUNT)) begin
                rd_val = count_q;
            end else begin
                rd_val = regs_q[rd_idx];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (r_state_q == R_IDLE) begin
            if (ar_fire) begin
                rid_d     = s_arid;
                rdata_d   = rd_val;
                rresp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                r_state_d = R_DATA;
            end
        end else if (s_rready) begin
            r_state_d = R_IDLE;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            awid_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            r_state_q  <= R_IDLE;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            src_prev_q <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            awid_q     <= awid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            r_state_q  <= r_state_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q     <= pend_d;
            src_prev_q <= irq_src;
            count_q    <= count_d;
            irq_q      <= irq_d;
        end
    end

    assign s_bvalid = (w_state_q == W_RESP);
    assign s_bid    = bid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = (r_state_q == R_DATA);
    assign s_rlast  = (r_state_q == R_DATA);
    assign s_rid    = rid_q;
    assign s_rdata  = rdata_q;
    assign s_rresp  = rresp_q;
    assign leds     = regs_q[IDX_CTRL][LED_W-1:0];
    assign irq      = irq_q;

endmodule

// File: tb/tb_axi_reg_bank.sv
// Directed, table-driven bench for axi_reg_bank (default parameters).
module tb_axi_reg_bank;

    localparam int ID_W = 12;

    logic            clock;
    logic            resetn;
    logic [31:0]     s_awaddr;
    logic [ID_W-1:0] s_awid;
    logic [2:0]      s_awprot;
    logic            s_awvalid;
    logic            s_awready;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic [ID_W-1:0] s_wid;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic [ID_W-1:0] s_bid;
    logic            s_bvalid;
    logic            s_bready;
    logic [31:0]     s_araddr;
    logic [ID_W-1:0] s_arid;
    logic [2:0]      s_arprot;
    logic            s_arvalid;
    logic            s_arready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic [ID_W-1:0] s_rid;
    logic            s_rlast;
    logic            s_rvalid;
    logic            s_rready;
    logic [3:0]      irq_src;
    logic [3:0]      leds;
    logic            irq;

    int errors = 0;
    int checks = 0;

    axi_reg_bank dut (
        .clock     (clock),
        .resetn    (resetn),
        .s_awaddr  (s_awaddr),
        .s_awid    (s_awid),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wid     (s_wid),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bid     (s_bid),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arid    (s_arid),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rid     (s_rid),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .irq_src   (irq_src),
        .leds      (leds),
        .irq       (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout required handshake", name);
    endtask

    // mode 0: AW and W together, 1: AW a cycle before W, 2: W before AW.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [ID_W-1:0] id,
                             input int mode, input int hold,
                             output logic [1:0] resp, output logic [ID_W-1:0] bid_o);
        bit aw_done, w_done, aw_f, w_f;
        int cyc;
        resp  = 2'bxx;
        bid_o = 'x;
        @(negedge clock);
        s_awaddr = addr;  s_awid = id;  s_wdata = data;  s_wstrb = strb;  s_wid = id;
        s_awvalid = (mode != 2);
        s_wvalid  = (mode != 1);
        s_bready  = 1'b0;
        aw_done = 0;  w_done = 0;  cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_f = s_awvalid && s_awready;
            w_f  = s_wvalid && s_wready;
            @(posedge clock); #1;
            if (aw_f) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_f)  begin s_wvalid  = 1'b0; w_done  = 1; end
            if (aw_done && !w_done) s_wvalid  = 1'b1;
            if (w_done && !aw_done) s_awvalid = 1'b1;
            @(negedge clock);
            cyc++;
        end
        if (!(aw_done && w_done)) begin
            timeout("write addr/data");
            s_awvalid = 1'b0;  s_wvalid = 1'b0;
            return;
        end
        cyc = 0;
        while (!s_bvalid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!s_bvalid) begin
            timeout("write resp");
            return;
        end
        resp  = s_bresp;
        bid_o = s_bid;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk($sformatf("bhold%0d bvalid", i), 32'(s_bvalid), 32'd1);
            chk($sformatf("bhold%0d bid", i), 32'(s_bid), 32'(id));
            chk($sformatf("bhold%0d awready", i), 32'(s_awready), 32'd0);
        end
        s_bready = 1'b1;
        @(posedge clock); #1;
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [ID_W-1:0] id,
                            input int hold, input logic [31:0] exp_data,
                            output logic [31:0] data, output logic [1:0] resp,
                            output logic [ID_W-1:0] rid_o, output logic last_o);
        int cyc;
        data = 'x;  resp = 2'bxx;  rid_o = 'x;  last_o = 1'bx;
        @(negedge clock);
        s_araddr = addr;  s_arid = id;  s_arvalid = 1'b1;  s_rready = 1'b0;
        cyc = 0;
        while (!s_arready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!s_arready) begin
            timeout("read addr");
            s_arvalid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        cyc = 0;
        while (!s_rvalid && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!s_rvalid) begin
            timeout("read data");
            return;
        end
        data = s_rdata;  resp = s_rresp;  rid_o = s_rid;  last_o = s_rlast;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk($sformatf("rhold%0d rvalid", i), 32'(s_rvalid), 32'd1);
            chk($sformatf("rhold%0d rdata", i), s_rdata, exp_data);
            chk($sformatf("rhold%0d arready", i), 32'(s_arready), 32'd0);
        end
        s_rready = 1'b1;
        @(posedge clock); #1;
        s_rready = 1'b0;
    endtask

    typedef struct {
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [3:0]      strb;
        logic [ID_W-1:0] id;
        int              mode;
        logic [1:0]      exp_bresp;
        bit              chk_rd;
        logic [31:0]     exp_rdata;
        logic [1:0]      exp_rresp;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    logic [1:0]      bresp_v, rresp_v;
    logic [ID_W-1:0] bid_v, rid_v;
    logic [31:0]     rdata_v;
    logic            rlast_v;

    initial begin
        vecs[0]  = '{32'h00, 32'h0000_000A, 4'hF, 12'h123, 1, 2'b00, 1, 32'h0000_000A, 2'b00};
        vecs[1]  = '{32'h10, 32'hAABB_CCDD, 4'hF, 12'h001, 0, 2'b00, 1, 32'hAABB_CCDD, 2'b00};
        vecs[2]  = '{32'h10, 32'h1122_3344, 4'h5, 12'h002, 2, 2'b00, 1, 32'hAA22_CC44, 2'b00};
        vecs[3]  = '{32'h04, 32'hFFFF_FFFF, 4'hF, 12'h003, 0, 2'b00, 1, 32'h0000_000F, 2'b00};
        vecs[4]  = '{32'h04, 32'h0000_0000, 4'hE, 12'h004, 1, 2'b00, 1, 32'h0000_000F, 2'b00};
        vecs[5]  = '{32'h0C, 32'h1234_5678, 4'hF, 12'h005, 0, 2'b00, 0, 32'h0,         2'b00};
        vecs[6]  = '{32'h200, 32'hDEAD_BEEF, 4'hF, 12'h006, 0, 2'b10, 1, 32'h0,        2'b10};
        vecs[7]  = '{32'h14, 32'h0BAD_F00D, 4'hF, 12'h007, 0, 2'b00, 1, 32'h0BAD_F00D, 2'b00};
        vecs[8]  = '{32'h1C, 32'h0102_0304, 4'h3, 12'h008, 2, 2'b00, 1, 32'h0000_0304, 2'b00};
        vecs[9]  = '{32'h20, 32'hFFFF_FFFF, 4'hF, 12'h009, 1, 2'b10, 1, 32'h0,         2'b10};
        vecs[10] = '{32'h1B, 32'h0000_005A, 4'h1, 12'h00A, 0, 2'b00, 1, 32'h0000_005A, 2'b00};
        vecs[11] = '{32'h08, 32'hFFFF_FFFF, 4'hF, 12'h00B, 0, 2'b00, 1, 32'h0,         2'b00};

        resetn = 1'b0;
        s_awaddr = '0; s_awid = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0;  s_wstrb = '0; s_wid = '0;   s_wvalid = 1'b0;
        s_bready = 1'b0;
        s_araddr = '0; s_arid = '0; s_arprot = '0; s_arvalid = 1'b0;
        s_rready = 1'b0;
        irq_src = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst awready", 32'(s_awready), 32'd0);
        chk("rst wready",  32'(s_wready),  32'd0);
        chk("rst arready", 32'(s_arready), 32'd0);
        chk("rst bvalid",  32'(s_bvalid),  32'd0);
        chk("rst rvalid",  32'(s_rvalid),  32'd0);
        chk("rst rlast",   32'(s_rlast),   32'd0);
        chk("rst leds",    32'(leds),      32'd0);
        chk("rst irq",     32'(irq),       32'd0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk("post-rst awready", 32'(s_awready), 32'd1);
        chk("post-rst wready",  32'(s_wready),  32'd1);
        chk("post-rst arready", 32'(s_arready), 32'd1);

        // Table-driven write / read-back
        for (int i = 0; i < NV; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].id, vecs[i].mode, 0,
                      bresp_v, bid_v);
            chk($sformatf("v%0d bresp", i), 32'(bresp_v), 32'(vecs[i].exp_bresp));
            chk($sformatf("v%0d bid", i),   32'(bid_v),   32'(vecs[i].id));
            if (i == 0) chk("v0 leds", 32'(leds), 32'hA);
            if (vecs[i].chk_rd) begin
                axi_read(vecs[i].addr, vecs[i].id ^ 12'hFFF, 0, 32'h0,
                         rdata_v, rresp_v, rid_v, rlast_v);
                chk($sformatf("v%0d rdata", i), rdata_v, vecs[i].exp_rdata);
                chk($sformatf("v%0d rresp", i), 32'(rresp_v), 32'(vecs[i].exp_rresp));
                chk($sformatf("v%0d rid", i),   32'(rid_v), 32'(vecs[i].id ^ 12'hFFF));
                chk($sformatf("v%0d rlast", i), 32'(rlast_v), 32'd1);
            end
        end
        // Out-of-range writes must not have aliased onto CTRL
        axi_read(32'h00, 12'h0C0, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("ctrl after slverr", rdata_v, 32'h0000_000A);
        chk("leds after slverr", 32'(leds), 32'hA);

        // Backpressure on B and R
        axi_write(32'h18, 32'h600D_CAFE, 4'hF, 12'h3C5, 0, 5, bresp_v, bid_v);
        chk("hold bid", 32'(bid_v), 32'h3C5);
        axi_read(32'h18, 12'h5A5, 5, 32'h600D_CAFE, rdata_v, rresp_v, rid_v, rlast_v);
        chk("hold rdata", rdata_v, 32'h600D_CAFE);
        chk("hold rid", 32'(rid_v), 32'h5A5);

        // Same-cycle read and write of one register returns the old value
        @(negedge clock);
        s_awaddr = 32'h14; s_awid = 12'h111; s_wdata = 32'h1234_5678; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_araddr = 32'h14; s_arid = 12'h777; s_arvalid = 1'b1;
        @(posedge clock); #1;
        s_arvalid = 1'b0;
        chk("rw-same bvalid", 32'(s_bvalid), 32'd1);
        chk("rw-same rvalid", 32'(s_rvalid), 32'd1);
        chk("rw-same rdata old", s_rdata, 32'h0BAD_F00D);
        @(posedge clock); #1;
        s_bready = 1'b0; s_rready = 1'b0;
        axi_read(32'h14, 12'h778, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("rw-same rdata new", rdata_v, 32'h1234_5678);

        // Interrupt: edge sets PEND, irq one cycle later
        axi_write(32'h04, 32'h1, 4'hF, 12'h020, 0, 0, bresp_v, bid_v);
        @(negedge clock);
        irq_src = 4'h1;
        @(posedge clock); #1;
        chk("irq not early", 32'(irq), 32'd0);
        @(posedge clock); #1;
        chk("irq asserted", 32'(irq), 32'd1);
        irq_src = 4'h0;
        axi_read(32'h08, 12'h021, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("pend after edge", rdata_v, 32'h1);

        // W1C landing in the same cycle as a fresh edge: set wins
        @(negedge clock);
        s_awaddr = 32'h08; s_awid = 12'h055; s_wdata = 32'h1; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        irq_src = 4'h1;
        @(posedge clock); #1;
        chk("w1c+edge bvalid", 32'(s_bvalid), 32'd1);
        @(posedge clock); #1;
        s_bready = 1'b0;
        irq_src = 4'h0;
        axi_read(32'h08, 12'h022, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("pend hw wins", rdata_v, 32'h1);
        chk("irq still set", 32'(irq), 32'd1);
        axi_write(32'h08, 32'h1, 4'hF, 12'h023, 0, 0, bresp_v, bid_v);
        chk("irq cleared", 32'(irq), 32'd0);
        axi_read(32'h08, 12'h024, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("pend cleared", rdata_v, 32'h0);

        // Reset in the middle of a write response
        @(negedge clock);
        s_awaddr = 32'h00; s_awid = 12'h0AB; s_wdata = 32'h3; s_wstrb = 4'hF;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge clock); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(posedge clock); #1;
        chk("pre-reset bvalid", 32'(s_bvalid), 32'd1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("mid-rst bvalid", 32'(s_bvalid), 32'd0);
        chk("mid-rst awready", 32'(s_awready), 32'd0);
        chk("mid-rst leds", 32'(leds), 32'd0);
        chk("mid-rst count", dut.count_q, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        s_bready = 1'b1;
        @(posedge clock); #1;
        chk("count restart", dut.count_q, 32'd1);
        chk("post-rst awready 2", 32'(s_awready), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        chk("no stale bvalid", 32'(s_bvalid), 32'd0);
        s_bready = 1'b0;
        axi_read(32'h00, 12'h0C1, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("ctrl after reset", rdata_v, 32'h0);
        axi_read(32'h10, 12'h0C2, 0, 32'h0, rdata_v, rresp_v, rid_v, rlast_v);
        chk("scratch after reset", rdata_v, 32'h0);

        // COUNT wrap, preloaded near the top
        @(negedge clock);
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        @(posedge clock); #1;
        chk("count max", dut.count_q, 32'hFFFF_FFFF);
        @(posedge clock); #1;
        chk("count wrap", dut.count_q, 32'h0);
        @(posedge clock); #1;
        chk("count after wrap", dut.count_q, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_reg_bank.md
AXI_REG_BANK -- requirements
Module: axi_reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8; number of 32-bit register slots, range 5..64.
REQ-002 SHALL have parameter ID_W, default 12; AXI ID width.
REQ-003 SHALL have parameter LED_W, default 4; LED output width, range 1..32.
REQ-004 SHALL have parameter N_IRQ, default 4; hardware interrupt sources, range 1..32.
REQ-005 Ports, in this order:
 clock  in  1  sole clock; all logic on its rising edge.
 resetn  in  1  asynchronous active-low reset.
 s_awaddr/awid/awprot/awvalid/awready  in/in/in/in/out  32/ID_W/3/1/1  AXI3 write address.
 s_wdata/wstrb/wid/wvalid/wready  in/in/in/in/out  32/4/ID_W/1/1  AXI3 write data; single beat only.
 s_bresp/bid/bvalid/bready  out/out/out/in  2/ID_W/1/1  write response.
 s_araddr/arid/arprot/arvalid/arready  in/in/in/in/out  32/ID_W/3/1/1  read address.
 s_rdata/rresp/rid/rlast/rvalid/rready  out/out/out/out/out/in  32/2/ID_W/1/1/1  read data.
 irq_src  in  N_IRQ  hardware event lines, synchronous to clock.
 leds  out  LED_W  CTRL[LED_W-1:0].
 irq  out  1  level interrupt: |(PEND & EN).

Function
REQ-006 Register index = addr[2+:clog2(NUM_REGS)]; addr[1:0] ignored; addr >= 4*NUM_REGS -> SLVERR (2'b10), no write, rdata 0.
REQ-007 Map: 0x00 CTRL rw; 0x04 IRQ_EN rw [N_IRQ-1:0]; 0x08 IRQ_PEND read / write-1-to-clear; 0x0C COUNT read-only (writes OKAY, ignored); 0x10..end SCRATCH rw.
REQ-008 Unimplemented bits of IRQ_EN/IRQ_PEND read 0.
REQ-009 Writes honour wstrb per byte; bytes with strobe 0 unchanged; W1C applies only to strobed bytes.
REQ-010 Write FSM states W_IDLE, W_RESP. In W_IDLE awready=1 until AW captured, wready=1 until W captured; AW and W accepted independently in either order or the same cycle.
REQ-011 Cycle after both AW and W are held: register updated, FSM -> W_RESP, bvalid=1, bid=captured awid, bresp per REQ-006; awready=wready=0 in W_RESP.
REQ-012 W_RESP -> W_IDLE on bvalid&bready; bid/bresp stable while bvalid=1 and bready=0.
REQ-013 Read FSM states R_IDLE, R_DATA. R_IDLE: arready=1; on arvalid, capture arid, latch rdata/rresp -> R_DATA next cycle (latency 1).
REQ-014 R_DATA: rvalid=1, rlast=1, arready=0; rdata/rid/rresp held until rready; then -> R_IDLE.
REQ-015 Read and write FSMs independent; same-cycle read and write of one register returns pre-write value.
REQ-016 irq_src rising edge (registered previous value) sets corresponding PEND bit.
REQ-017 Set and W1C of the same PEND bit in the same cycle: bit ends 1 (hardware wins).
REQ-018 COUNT is a free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0.
REQ-019 irq registered: asserts the cycle after PEND&EN becomes non-zero.
REQ-020 wid is not checked against awid; awprot/arprot ignored.

Reset
REQ-021 resetn low asynchronously forces: all registers, COUNT, edge history, captured IDs = 0; both FSMs idle; awready=wready=arready=0 during reset, 1 the first cycle after release; bvalid=rvalid=rlast=0; bresp=rresp=0; leds=0; irq=0.
REQ-022 Reset mid-transaction abandons it; no response issued after release.

Structure
REQ-023 Register offsets, FSM state enums, RESP_OKAY/RESP_SLVERR constants SHALL reside in shared package axi_reg_pkg.
REQ-024 Per-byte strobed update SHALL be one sub-module, axi_strb_merge (old, new, strb -> merged), reused for rw and W1C paths.

Verification
REQ-025 Write 0x00=0x0000000A strb 0xF, AW one cycle before W, awid 0x123 -> bid 0x123, bresp 0, leds=4'hA.
REQ-026 Write 0x10=0xAABBCCDD strb 0xF, then 0x10=0x11223344 strb 0x5 -> read 0x10 gives 0xAA22CC44, rid echoed, rlast=1.
REQ-027 Read 0x200 (NUM_REGS=8) -> rresp 2'b10, rdata 0; write 0x200 -> bresp 2'b10, no register changes.
REQ-028 IRQ_EN=0x1, pulse irq_src[0] -> PEND=0x1, irq=1 one cycle after; W1C 0x1 in the same cycle as a new irq_src[0] edge -> PEND stays 1; later W1C alone -> irq=0.
REQ-029 Hold bready=0 for 5 cycles after write -> bvalid, bid stable, awready=0; rready=0 on read likewise holds rdata.
REQ-030 Drop resetn during W_RESP -> bvalid=0 immediately, registers 0, COUNT restarts at 0 and wraps after 2^32 cycles (force test).
